// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: a FETCH/WAIT/HOLD machine that issues one read at a time,
// presents the returned word to the decoder and advances or redirects the PC on consume.
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fault,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst_q;
    logic        fault_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        arvalid_q;
    logic        rready_q;
    logic        ivalid_q;

    // Next PC and consume count for the handshake edge; jump targets are word aligned.
    always_comb begin
        pc_d  = pc_q + 32'd4;
        cnt_d = cnt_q + 32'd1;
        if (jump) begin
            pc_d = {jump_addr[31:2], 2'b00};
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Fetch FSM with the handshake flags registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0000_0000;
            fault_q   <= 1'b0;
            cnt_q     <= 32'h0000_0000;
            arvalid_q <= 1'b1;
            rready_q  <= 1'b0;
            ivalid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_arready) begin
                        state_q   <= S_WAIT;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        inst_q   <= mem_rdata;
                        fault_q  <= (mem_rresp != 2'b00);
                        state_q  <= S_HOLD;
                        rready_q <= 1'b0;
                        ivalid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        pc_q      <= pc_d;
                        cnt_q     <= cnt_d;
                        state_q   <= S_FETCH;
                        ivalid_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_FETCH;
                    arvalid_q <= 1'b1;
                    rready_q  <= 1'b0;
                    ivalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // The request is held off while reset is asserted even though the state already reads FETCH.
    assign mem_arvalid = arvalid_q & ~rst;
    assign mem_araddr  = pc_q;
    assign mem_rready  = rready_q;
    assign inst_valid  = ivalid_q;
    assign inst        = inst_q;
    assign pc          = pc_q;
    assign fault       = fault_q;
    assign fetch_cnt   = cnt_q;

endmodule
